// File: rtl/pix_dispatch.sv
// Pixel work dispatcher: walks an external pixel counter over a frame and issues
// one (x, y, re, im) packet per pixel to a compute core, one packet per two cycles.
module pix_dispatch #(
  parameter int NUM_X_BITS = 10,
  parameter int NUM_Y_BITS = 10,
  parameter int COORD_BITS = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_X_BITS-1:0] x_max,
  input  logic [NUM_Y_BITS-1:0] y_max,
  input  logic [COORD_BITS-1:0] re_start,
  input  logic [COORD_BITS-1:0] im_start,
  input  logic [COORD_BITS-1:0] re_step,
  input  logic [COORD_BITS-1:0] im_step,
  input  logic [NUM_X_BITS-1:0] x_value,
  input  logic [NUM_Y_BITS-1:0] y_value,
  input  logic                  done,
  output logic                  pix_count_enable,
  output logic                  pix_clear,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [NUM_X_BITS-1:0] pkt_x,
  output logic [NUM_Y_BITS-1:0] pkt_y,
  output logic [COORD_BITS-1:0] pkt_re,
  output logic [COORD_BITS-1:0] pkt_im,
  output logic                  busy,
  output logic                  frame_done
);

  typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, SETTLE, FINISH} state_e;

  state_e                state_q;
  logic [NUM_X_BITS-1:0] x_max_q;
  logic [NUM_Y_BITS-1:0] y_max_q;
  logic [COORD_BITS-1:0] re_start_q, im_start_q, re_step_q, im_step_q;
  logic [COORD_BITS-1:0] re_acc_q, im_acc_q;
  logic                  hs;

  // Abort wins over a same-cycle handshake, so it also suppresses the counter pulse.
  assign pkt_valid        = (state_q == ISSUE);
  assign hs               = pkt_valid && pkt_ready && !abort;
  assign pix_count_enable = hs && !done;
  assign pix_clear        = (state_q == CLEAR);
  assign frame_done       = (state_q == FINISH);
  assign busy             = (state_q != IDLE);
  assign pkt_x            = x_value;
  assign pkt_y            = y_value;
  assign pkt_re           = re_acc_q;
  assign pkt_im           = im_acc_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      x_max_q    <= '0;
      y_max_q    <= '0;
      re_start_q <= '0;
      im_start_q <= '0;
      re_step_q  <= '0;
      im_step_q  <= '0;
      re_acc_q   <= '0;
      im_acc_q   <= '0;
    end else if (state_q != IDLE && abort) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) state_q <= CLEAR;
        CLEAR: begin
          x_max_q    <= x_max;
          y_max_q    <= y_max;
          re_start_q <= re_start;
          im_start_q <= im_start;
          re_step_q  <= re_step;
          im_step_q  <= im_step;
          re_acc_q   <= re_start;
          im_acc_q   <= im_start;
          state_q    <= ISSUE;
        end
        ISSUE: if (pkt_ready) begin
          if (done) begin
            state_q <= FINISH;
          end else begin
            state_q <= SETTLE;
            // End of row: rewind real axis, step imaginary axis.
            if (x_value == x_max_q) begin
              re_acc_q <= re_start_q;
              im_acc_q <= im_acc_q + im_step_q;
            end else begin
              re_acc_q <= re_acc_q + re_step_q;
            end
          end
        end
        SETTLE:  state_q <= ISSUE;
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // The external counter must agree with the frame geometry latched at CLEAR.
  a_done_geom: assert property (@(posedge clk) disable iff (!n_rst)
    (state_q == ISSUE && done) |-> (x_value == x_max_q && y_value == y_max_q));
  a_origin_im: assert property (@(posedge clk) disable iff (!n_rst)
    (state_q == ISSUE && x_value == '0 && y_value == '0) |-> (im_acc_q == im_start_q));

endmodule

// File: doc/pix_dispatch.md
PIX_DISPATCH -- requirements
Module: pix_dispatch

Interface
REQ-001 Parameters SHALL be:
- NUM_X_BITS, default 10, pixel x width.
- NUM_Y_BITS, default 10, pixel y width.
- COORD_BITS, default 32, signed two's-complement fixed-point coordinate width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame.
- abort  in  1  level; cancels the frame.
- x_max  in  NUM_X_BITS  last column index.
- y_max  in  NUM_Y_BITS  last row index.
- re_start  in  COORD_BITS  real coordinate of column 0.
- im_start  in  COORD_BITS  imaginary coordinate of row 0.
- re_step  in  COORD_BITS  real increment per column.
- im_step  in  COORD_BITS  imaginary increment per row.
- x_value  in  NUM_X_BITS  current column from the pixel counter.
- y_value  in  NUM_Y_BITS  current row from the pixel counter.
- done  in  1  high when x_value==x_max and y_value==y_max.
- pix_count_enable  out  1  one-cycle advance pulse to the pixel counter.
- pix_clear  out  1  one-cycle clear pulse to the pixel counter.
- pkt_valid  out  1  work packet valid.
- pkt_ready  in  1  downstream compute core accepts the packet.
- pkt_x  out  NUM_X_BITS  packet column.
- pkt_y  out  NUM_Y_BITS  packet row.
- pkt_re  out  COORD_BITS  packet real coordinate.
- pkt_im  out  COORD_BITS  packet imaginary coordinate.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse after the final packet is accepted.

REQ-003 Reset SHALL be asynchronous and active-low on n_rst, with a single clock clk.

Function
REQ-004 The FSM SHALL have the states IDLE, CLEAR, ISSUE, SETTLE and FINISH.

REQ-005 IDLE: when start=1, the block SHALL go to CLEAR; all other inputs are ignored in IDLE.

REQ-006 CLEAR SHALL last one cycle:
- pix_clear=1.
- Latch x_max, y_max, re_start, im_start, re_step and im_step into shadow registers.
- Set re_acc=re_start and im_acc=im_start.
- Next state ISSUE.

REQ-007 ISSUE: pkt_valid=1, pkt_x=x_value, pkt_y=y_value, pkt_re=re_acc and pkt_im=im_acc, all combinational from registers and held stable until the handshake.

REQ-008 A handshake SHALL occur when pkt_valid and pkt_ready are both 1 on the same rising edge; with no handshake the block SHALL stay in ISSUE with all packet fields unchanged.

REQ-009 On a handshake with done=0:
- pix_count_enable=1 for exactly that cycle.
- Next state SETTLE.
- If x_value==shadow x_max: re_acc<=shadow re_start and im_acc<=im_acc+im_step.
- Otherwise: re_acc<=re_acc+re_step.

REQ-010 SETTLE SHALL last one cycle with pkt_valid=0, then go to ISSUE; sustained throughput is therefore 1 packet per 2 cycles.

REQ-011 On a handshake with done=1, the block SHALL go to FINISH without pulsing pix_count_enable.

REQ-012 FINISH SHALL last one cycle with frame_done=1, then go to IDLE.

REQ-013 All accumulator additions SHALL wrap modulo 2^COORD_BITS, with no saturation and no overflow flag.

REQ-014 abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
- pkt_valid=0 from that edge.
- No frame_done.
- No pix_count_enable on that cycle.
- abort takes priority over a simultaneous handshake.

REQ-015 start asserted while busy=1 SHALL be ignored.

REQ-016 Input changes to x_max, y_max or any coordinate parameter after CLEAR SHALL have no effect until the next frame.

REQ-017 busy=1 in CLEAR, ISSUE, SETTLE and FINISH; busy=0 in IDLE.

REQ-018 pix_count_enable and pix_clear SHALL never be high in the same cycle.

REQ-019 Exactly (x_max+1)*(y_max+1) handshakes SHALL occur per non-aborted frame, in raster order (x fastest).

Reset
REQ-020 While n_rst=0, the block SHALL hold state IDLE with re_acc=0, im_acc=0 and all shadow registers 0.

REQ-021 While n_rst=0, every 1-bit output SHALL be 0.

REQ-022 Reset asserted mid-frame SHALL take effect immediately (asynchronous), and a new start pulse is required afterwards.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Full frame: x_max=1, y_max=1, re_start=0xF0000000, re_step=0x01000000, im_start=0x10000000, im_step=0xFF000000, pkt_ready=1 -> 4 packets (x,y,re,im) = (0,0,F0000000,10000000), (1,0,F1000000,10000000), (0,1,F0000000,0F000000), (1,1,F1000000,0F000000); frame_done pulses 1 cycle after the 4th; 3 pix_count_enable pulses total.
- Backpressure: pkt_ready=0 for 5 cycles on packet 2 -> pkt_valid stays 1, fields unchanged, no pix_count_enable until ready.
- Abort: abort=1 in the same cycle as the handshake of packet 2 -> IDLE next edge, pkt_valid=0, no pix_count_enable, frame_done never pulses.
- Wrap: re_start=0x7FFFFFFF, re_step=1, x_max=1 -> second packet pkt_re=0x80000000.
- Busy start: start pulsed during ISSUE -> no pix_clear, packet sequence unaffected.
- Reset: n_rst low mid-frame -> busy, pkt_valid and all pulses 0 immediately; no activity until the next start.
